// File: rtl/button_stimulus_pkg.sv
// Shared FSM encoding and LFSR constants for the button stimulus generator.
// No timing or backpressure: definitions only.
package button_stimulus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRESS   = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_GAP     = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    // Right-shifting Galois step: the bit shifted out decides whether the taps are applied.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/button_stimulus_if.sv
// Command/status bundle between a press requester and the button stimulus generator.
// start is a plain request level; there is no ready, starts while busy are dropped.
interface button_stimulus_if #(
    parameter int HOLD_W = 16
);
    logic              start;
    logic              bounce_en;
    logic [HOLD_W-1:0] hold_cycles;
    logic              button_out;
    logic              busy;
    logic              done;

    modport master (
        output start, bounce_en, hold_cycles,
        input  button_out, busy, done
    );

    modport slave (
        input  start, bounce_en, hold_cycles,
        output button_out, busy, done
    );
endinterface

// File: rtl/button_stimulus_lfsr.sv
// 16-bit Galois LFSR, advances one step per cycle when step is high; low bits exposed.
// Output is the registered state, so a step shows up on the next cycle; never stalls.
module lfsr16
    import button_stimulus_pkg::*;
#(
    parameter logic [15:0] SEED  = LFSR_SEED_DEFAULT,
    parameter int          OUT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step,
    output logic [OUT_W-1:0] low
);
    logic [15:0] st;

    always_ff @(posedge clk) begin
        if (reset) begin
            st <= SEED;
        end else if (step) begin
            st <= lfsr_next(st);
        end
    end

    assign low = st[OUT_W-1:0];

endmodule

// File: rtl/button_stimulus.sv
// Emulates a mechanical button press (bouncy press, hold, bouncy release, quiet gap) per start.
// First edge one cycle after start is sampled; start outside IDLE is ignored, not queued.
module button_stimulus
    import button_stimulus_pkg::*;
#(
    parameter int          BOUNCE_PAIRS = 2,
    parameter int          GLITCH_W     = 3,
    parameter int          HOLD_W       = 16,
    parameter int          GAP_CYCLES   = 8,
    parameter logic [15:0] LFSR_SEED    = LFSR_SEED_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    button_stimulus_if.slave   bus
);
    localparam int NT     = 2 * BOUNCE_PAIRS + 1;
    localparam int CNT_W  = $clog2(NT + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int TW0    = (HOLD_W > GLITCH_W) ? HOLD_W : GLITCH_W;
    localparam int TMR_W  = (TW0 > GAP_W) ? TW0 : GAP_W;

    state_t             state;
    logic [TMR_W-1:0]   timer;
    logic [CNT_W-1:0]   tog_left;
    logic               bounce_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [HOLD_W-1:0]  hold_m1;
    logic               button_q;
    logic               busy_q;
    logic               done_q;
    logic               lfsr_step;
    logic [GLITCH_W-1:0] glitch_lsb;

    lfsr16 #(
        .SEED  (LFSR_SEED),
        .OUT_W (GLITCH_W)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .step  (lfsr_step),
        .low   (glitch_lsb)
    );

    // A toggle that is not the last of its phase consumes one LFSR value for the next interval.
    always_comb begin
        lfsr_step = 1'b0;
        if ((state == ST_PRESS || state == ST_HOLD || state == ST_RELEASE) &&
            timer == '0 && tog_left != CNT_W'(1)) begin
            lfsr_step = 1'b1;
        end
    end

    assign hold_m1 = (hold_q == '0) ? '0 : hold_q - 1'b1;

    // Timers hold (interval - 1): an event fires at the edge where the timer reads zero.
    // HOLD's expiry edge is the first RELEASE toggle, so HOLD and RELEASE share the toggle path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            timer    <= '0;
            tog_left <= '0;
            bounce_q <= 1'b0;
            hold_q   <= '0;
            button_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        bounce_q <= bus.bounce_en;
                        hold_q   <= bus.hold_cycles;
                        timer    <= '0;
                        tog_left <= bus.bounce_en ? CNT_W'(NT) : CNT_W'(1);
                        state    <= ST_PRESS;
                    end
                end
                ST_PRESS, ST_HOLD, ST_RELEASE: begin
                    if (timer == '0) begin
                        button_q <= ~button_q;
                        busy_q   <= 1'b1;
                        if (tog_left == CNT_W'(1)) begin
                            if (state == ST_PRESS) begin
                                state    <= ST_HOLD;
                                timer    <= TMR_W'(hold_m1);
                                tog_left <= bounce_q ? CNT_W'(NT) : CNT_W'(1);
                            end else begin
                                state <= ST_GAP;
                                timer <= TMR_W'(GAP_CYCLES - 1);
                            end
                        end else begin
                            timer    <= TMR_W'(glitch_lsb);
                            tog_left <= tog_left - 1'b1;
                            if (state == ST_HOLD) begin
                                state <= ST_RELEASE;
                            end
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (timer == '0) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.button_out = button_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;

endmodule

// File: tb/tb_button_stimulus.sv
// Directed bench for button_stimulus: clean/bouncy presses, hold floor, reset abort,
// back-to-back starts, and a behavioural debounce + one-shot downstream.
module tb_button_stimulus;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    button_stimulus_if #(.HOLD_W(16)) bus ();

    button_stimulus #(
        .BOUNCE_PAIRS (2),
        .GLITCH_W     (3),
        .HOLD_W       (16),
        .GAP_CYCLES   (8),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   edge_n   = 0;
    int   tog_q[$];
    logic lvl_q[$];
    logic prev_btn = 1'b0;
    int   done_cnt = 0;

    always @(posedge clk) edge_n++;

    // Output monitor: records each button_out change with the edge that produced it.
    always @(negedge clk) begin
        if (bus.button_out !== prev_btn) begin
            tog_q.push_back(edge_n);
            lvl_q.push_back(bus.button_out);
        end
        prev_btn = bus.button_out;
        if (bus.done === 1'b1) done_cnt++;
    end

    // Downstream conditioner model: 2-flop sync, 16-cycle stability debounce, rising one-shot.
    logic s1 = 1'b0, s2 = 1'b0, db_lvl = 1'b0;
    int   db_cnt    = 0;
    int   pulse_cnt = 0;
    always @(posedge clk) begin
        s1 <= bus.button_out;
        s2 <= s1;
        if (s2 != db_lvl) begin
            if (db_cnt == 15) begin
                db_lvl <= s2;
                db_cnt <= 0;
                if (s2) pulse_cnt <= pulse_cnt + 1;
            end else begin
                db_cnt <= db_cnt + 1;
            end
        end else begin
            db_cnt <= 0;
        end
    end

    task automatic check(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic bit [15:0] ref_step(input bit [15:0] s);
        bit fb;
        fb = s[0];
        s  = s >> 1;
        if (fb) s = s ^ 16'hB400;
        return s;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start(input logic b, input int h, output int k);
        @(negedge clk);
        bus.start       = 1'b1;
        bus.bounce_en   = b;
        bus.hold_cycles = 16'(h);
        k = edge_n + 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) break;
        end
        check("wait_done", int'(bus.done), 1);
    endtask

    task automatic wait_toggles(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tog_q.size() >= n) break;
        end
        check("wait_toggles", int'(tog_q.size() >= n), 1);
    endtask

    // Checks a full bouncy sequence started right after reset (LFSR at seed).
    task automatic check_bouncy(input int k, input int hold);
        bit [15:0] m;
        int exp_t;
        m = 16'hACE1;
        check("bouncy_toggle_count", tog_q.size(), 10);
        if (tog_q.size() < 10) return;
        exp_t = k + 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                exp_t = exp_t + ((hold < 1) ? 1 : hold);
            end else if (i != 0) begin
                exp_t = exp_t + 1 + int'(m[2:0]);
                m = ref_step(m);
            end
            check($sformatf("bouncy_edge%0d", i), tog_q[i], exp_t);
            check($sformatf("bouncy_level%0d", i), int'(lvl_q[i]), (i % 2 == 0) ? 1 : 0);
        end
    endtask

    initial begin
        int k, k2, d0, pc;
        bus.start       = 1'b0;
        bus.bounce_en   = 1'b0;
        bus.hold_cycles = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_button", int'(bus.button_out), 0);
        check("rst_busy",   int'(bus.busy), 0);
        check("rst_done",   int'(bus.done), 0);
        reset = 1'b0;

        // 1: clean edges, hold 10, gap 8
        do_start(1'b0, 10, k);
        for (int rel = 0; rel <= 21; rel++) begin
            if (rel > 0) @(negedge clk);
            check($sformatf("t1_button@%0d", rel), int'(bus.button_out), (rel >= 1 && rel <= 10) ? 1 : 0);
            check($sformatf("t1_busy@%0d", rel),   int'(bus.busy),       (rel >= 1 && rel <= 18) ? 1 : 0);
            check($sformatf("t1_done@%0d", rel),   int'(bus.done),       (rel == 19) ? 1 : 0);
        end

        // 2: bouncy press from reset, intervals from the reference LFSR
        apply_reset();
        tog_q.delete(); lvl_q.delete();
        do_start(1'b1, 20, k);
        wait_done(400);
        check("t2_final_level", int'(bus.button_out), 0);
        check_bouncy(k, 20);

        // 3: hold=0 floors to one cycle; starts while busy are dropped
        repeat (2) @(negedge clk);
        tog_q.delete(); lvl_q.delete();
        d0 = done_cnt;
        do_start(1'b0, 0, k);
        @(negedge clk);
        check("t3_high", int'(bus.button_out), 1);
        bus.start = 1'b1;
        @(negedge clk);
        check("t3_low", int'(bus.button_out), 0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(100);
        repeat (30) @(negedge clk);
        check("t3_toggles", tog_q.size(), 2);
        if (tog_q.size() >= 2) begin
            check("t3_rise_edge", tog_q[0], k + 1);
            check("t3_fall_edge", tog_q[1], k + 2);
        end
        check("t3_done_pulses", done_cnt - d0, 1);

        // 4: reset mid-HOLD aborts, then the LFSR replays from seed
        apply_reset();
        tog_q.delete(); lvl_q.delete();
        do_start(1'b1, 50, k);
        wait_toggles(5, 200);
        repeat (10) @(negedge clk);
        check("t4_in_hold", int'(bus.button_out), 1);
        reset = 1'b1;
        @(negedge clk);
        check("t4_rst_button", int'(bus.button_out), 0);
        check("t4_rst_busy",   int'(bus.busy), 0);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (30) @(negedge clk);
        check("t4_no_done", done_cnt - d0, 0);
        tog_q.delete(); lvl_q.delete();
        do_start(1'b1, 5, k);
        wait_done(400);
        check_bouncy(k, 5);

        // 5: start in the done cycle is accepted
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        do_start(1'b0, 3, k);
        wait_done(100);
        bus.start = 1'b1;
        k2 = edge_n + 1;
        @(negedge clk);
        bus.start = 1'b0;
        check("t5_busy_k", int'(bus.busy), 0);
        @(negedge clk);
        check("t5_button_k1", int'(bus.button_out), 1);
        check("t5_busy_k1",   int'(bus.busy), 1);
        wait_done(100);
        repeat (3) @(negedge clk);
        check("t5_done_pulses", done_cnt - d0, 2);

        // 6: three bouncy presses through the conditioner model
        apply_reset();
        for (int p = 0; p < 3; p++) begin
            pc = pulse_cnt;
            tog_q.delete(); lvl_q.delete();
            do_start(1'b1, 2000, k);
            wait_toggles(5, 200);
            @(negedge clk);
            check($sformatf("t6_no_pulse_bounce%0d", p), pulse_cnt - pc, 0);
            wait_done(2300);
            repeat (40) @(negedge clk);
            check($sformatf("t6_one_pulse%0d", p), pulse_cnt - pc, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
